// File: rtl/elevator_motion_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_motion_scheduler
//
// Schedules car motion and door timing against a once-per-second tick pulse.
// Floor calls are latched into a pending set. Travel direction follows SCAN:
// the car keeps its direction while calls remain ahead of it, and turns
// around only when nothing is left in that direction. The car is always in
// one of three phases: IDLE, MOVE or DOOR. MOVE and DOOR are timed by
// counting tick pulses, so clock cycles without a tick do not advance timing.
//
// Ports
//   clk            in   1         system clock, the only clock
//   rst            in   1         synchronous, active-high reset
//   tick           in   1         one-clk pulse per time-base period
//   call_req       in   N_FLOORS  per-floor call, level or pulse, sampled every clk
//   current_floor  out  FLOOR_W   floor the car is at
//   moving_up      out  1         motor up command
//   moving_down    out  1         motor down command
//   door_open      out  1         door open command
//   pending        out  N_FLOORS  latched calls that have not been served
//   busy           out  1         car not idle, or calls pending
// All outputs are registered.
// -----------------------------------------------------------------------------
module elevator_motion_scheduler #(
    parameter int N_FLOORS     = 4,
    parameter int FLOOR_W      = 2,
    parameter int TRAVEL_TICKS = 2,
    parameter int DOOR_TICKS   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [N_FLOORS-1:0] call_req,
    output logic [FLOOR_W-1:0]  current_floor,
    output logic                moving_up,
    output logic                moving_down,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending,
    output logic                busy
);

    localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CNT_W-1:0]    TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0]    DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0]  TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);
    localparam logic [N_FLOORS-1:0] ONE_HOT0    = N_FLOORS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_e;

    // dir: 1 = up, 0 = down
    state_e                state_q, state_d;
    logic                  dir_q, dir_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [N_FLOORS-1:0]   pend_q, pend_d;
    logic                  up_q, up_d;
    logic                  down_q, down_d;
    logic                  door_q, door_d;
    logic                  busy_q, busy_d;

    logic [N_FLOORS-1:0]   cur_oh_s;
    logic [N_FLOORS-1:0]   next_oh_s;
    logic [N_FLOORS-1:0]   req_s;
    logic [FLOOR_W-1:0]    next_floor_s;

    // Floors strictly beyond flr in the given direction.
    function automatic logic [N_FLOORS-1:0] ahead_mask(input logic [FLOOR_W-1:0] flr,
                                                       input logic               up);
        logic [N_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (up) begin
                m[i] = (i > int'(flr));
            end else begin
                m[i] = (i < int'(flr));
            end
        end
        return m;
    endfunction

    // Request view, one-hot floor masks and the neighbouring floor in dir.
    always_comb begin
        cur_oh_s = ONE_HOT0 << floor_q;
        // While the door is open, a call at this floor only re-opens the door.
        if (state_q == ST_DOOR) begin
            req_s = pend_q | (call_req & ~cur_oh_s);
        end else begin
            req_s = pend_q | call_req;
        end
        // Saturate at the shaft ends so the floor index never leaves range.
        if (dir_q) begin
            if (floor_q < TOP_FLOOR) begin
                next_floor_s = floor_q + FLOOR_W'(1);
            end else begin
                next_floor_s = floor_q;
            end
        end else begin
            if (floor_q != FLOOR_W'(0)) begin
                next_floor_s = floor_q - FLOOR_W'(1);
            end else begin
                next_floor_s = floor_q;
            end
        end
        next_oh_s = ONE_HOT0 << next_floor_s;
    end

    // Phase sequencing, SCAN direction choice and pending-call bookkeeping.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        floor_d = floor_q;
        pend_d  = req_s;
        case (state_q)
            ST_IDLE: begin
                if (|(req_s & cur_oh_s)) begin
                    state_d = ST_DOOR;
                    cnt_d   = CNT_W'(0);
                    pend_d  = req_s & ~cur_oh_s;
                end else if (|(req_s & ahead_mask(floor_q, dir_q))) begin
                    state_d = ST_MOVE;
                    cnt_d   = CNT_W'(0);
                end else if (|(req_s & ahead_mask(floor_q, ~dir_q))) begin
                    dir_d   = ~dir_q;
                    state_d = ST_MOVE;
                    cnt_d   = CNT_W'(0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (tick) begin
                    if (cnt_q == TRAVEL_LAST) begin
                        // Arrival: a call raised on this very clk is included.
                        floor_d = next_floor_s;
                        cnt_d   = CNT_W'(0);
                        if (|(req_s & next_oh_s)) begin
                            state_d = ST_DOOR;
                            pend_d  = req_s & ~next_oh_s;
                        end else if (|(req_s & ahead_mask(next_floor_s, dir_q))) begin
                            state_d = ST_MOVE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DOOR: begin
                if (|(call_req & cur_oh_s)) begin
                    // Re-open: restart the dwell, takes priority over a tick.
                    cnt_d = CNT_W'(0);
                end else if (tick) begin
                    if (cnt_q == DOOR_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_W'(0);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_W'(0);
            end
        endcase
        // Outputs follow the next phase so they line up with the state change.
        up_d   = (state_d == ST_MOVE) && dir_d;
        down_d = (state_d == ST_MOVE) && !dir_d;
        door_d = (state_d == ST_DOOR);
        busy_d = (state_d != ST_IDLE) || (|pend_d);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b1;
            cnt_q   <= CNT_W'(0);
            floor_q <= FLOOR_W'(0);
            pend_q  <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            door_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            floor_q <= floor_d;
            pend_q  <= pend_d;
            up_q    <= up_d;
            down_q  <= down_d;
            door_q  <= door_d;
            busy_q  <= busy_d;
        end
    end

    assign current_floor = floor_q;
    assign moving_up     = up_q;
    assign moving_down   = down_q;
    assign door_open     = door_q;
    assign pending       = pend_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_elevator_motion_scheduler.sv
module tb_elevator_motion_scheduler;

    localparam int NF     = 4;
    localparam int TRAVEL = 2;
    localparam int DWELL  = 4;
    localparam int IDLE_P = 0;
    localparam int MOVE_P = 1;
    localparam int DOOR_P = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [3:0]  call_req = 4'b0000;
    logic [1:0]  current_floor;
    logic        moving_up, moving_down, door_open, busy;
    logic [3:0]  pending;
    logic [9:0]  dut_vec;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: car position, travel sense (+1/-1), phase and timer.
    int      m_floor = 0;
    int      m_dir   = 1;
    int      m_phase = IDLE_P;
    int      m_cnt   = 0;
    bit [3:0] m_pend = 4'b0000;

    typedef struct {
        logic       r;
        logic       t;
        logic [3:0] c;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[19];
    int   door_floors[$];

    elevator_motion_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick), .call_req(call_req),
        .current_floor(current_floor), .moving_up(moving_up),
        .moving_down(moving_down), .door_open(door_open),
        .pending(pending), .busy(busy)
    );

    assign dut_vec = {current_floor, moving_up, moving_down, door_open, pending, busy};

    always #5 clk = ~clk;

    function automatic bit any_ahead(int flr, int d, bit [3:0] r);
        for (int f = 0; f < NF; f++) begin
            if (r[f] && ((f - flr) * d > 0)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [9:0] model_vec();
        logic up, dn, dr, bz;
        up = (m_phase == MOVE_P) && (m_dir > 0);
        dn = (m_phase == MOVE_P) && (m_dir < 0);
        dr = (m_phase == DOOR_P);
        bz = (m_phase != IDLE_P) || (m_pend != 4'b0000);
        return {2'(m_floor), up, dn, dr, m_pend, bz};
    endfunction

    task automatic model_step(input logic r, input logic t, input logic [3:0] c);
        bit [3:0] req;
        if (r) begin
            m_floor = 0; m_dir = 1; m_phase = IDLE_P; m_cnt = 0; m_pend = 4'b0000;
            return;
        end
        req = m_pend | c;
        if (m_phase == DOOR_P) req[m_floor] = m_pend[m_floor];
        if (m_phase == IDLE_P) begin
            if (req[m_floor]) begin
                m_phase = DOOR_P; m_cnt = 0; req[m_floor] = 1'b0;
            end else if (any_ahead(m_floor, m_dir, req)) begin
                m_phase = MOVE_P; m_cnt = 0;
            end else if (any_ahead(m_floor, -m_dir, req)) begin
                m_dir = -m_dir; m_phase = MOVE_P; m_cnt = 0;
            end
        end else if (m_phase == MOVE_P) begin
            if (t) begin
                m_cnt++;
                if (m_cnt == TRAVEL) begin
                    m_floor += m_dir; m_cnt = 0;
                    if (req[m_floor]) begin
                        m_phase = DOOR_P; req[m_floor] = 1'b0;
                    end else if (!any_ahead(m_floor, m_dir, req)) begin
                        m_phase = IDLE_P;
                    end
                end
            end
        end else begin
            if (c[m_floor]) begin
                m_cnt = 0;
            end else if (t) begin
                m_cnt++;
                if (m_cnt == DWELL) begin
                    m_phase = IDLE_P; m_cnt = 0;
                end
            end
        end
        m_pend = req;
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b (floor,up,dn,door,pend,busy) at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One clock: drive on negedge, sample 1 time unit after posedge, compare.
    task automatic cyc(input logic r, input logic t, input logic [3:0] c);
        @(negedge clk);
        rst = r; tick = t; call_req = c;
        @(posedge clk);
        #1;
        model_step(r, t, c);
        check("model", dut_vec, model_vec());
        check("motor_door_excl",
              {8'd0, moving_up & moving_down, door_open & (moving_up | moving_down)},
              10'd0);
    endtask

    initial begin
        int n_t;
        logic prev_door;

        // Scenario 1 (call to top floor) then scenario 2 (call at current floor)
        tbl[0]  = '{1'b1, 1'b0, 4'b0000, 10'b00_0_0_0_0000_0};
        tbl[1]  = '{1'b0, 1'b0, 4'b1000, 10'b00_1_0_0_1000_1};
        tbl[2]  = '{1'b0, 1'b1, 4'b0000, 10'b00_1_0_0_1000_1};
        tbl[3]  = '{1'b0, 1'b1, 4'b0000, 10'b01_1_0_0_1000_1};
        tbl[4]  = '{1'b0, 1'b1, 4'b0000, 10'b01_1_0_0_1000_1};
        tbl[5]  = '{1'b0, 1'b1, 4'b0000, 10'b10_1_0_0_1000_1};
        tbl[6]  = '{1'b0, 1'b1, 4'b0000, 10'b10_1_0_0_1000_1};
        tbl[7]  = '{1'b0, 1'b1, 4'b0000, 10'b11_0_0_1_0000_1};
        tbl[8]  = '{1'b0, 1'b1, 4'b0000, 10'b11_0_0_1_0000_1};
        tbl[9]  = '{1'b0, 1'b1, 4'b0000, 10'b11_0_0_1_0000_1};
        tbl[10] = '{1'b0, 1'b1, 4'b0000, 10'b11_0_0_1_0000_1};
        tbl[11] = '{1'b0, 1'b1, 4'b0000, 10'b11_0_0_0_0000_0};
        tbl[12] = '{1'b1, 1'b0, 4'b0000, 10'b00_0_0_0_0000_0};
        tbl[13] = '{1'b0, 1'b0, 4'b0001, 10'b00_0_0_1_0000_1};
        tbl[14] = '{1'b0, 1'b1, 4'b0000, 10'b00_0_0_1_0000_1};
        tbl[15] = '{1'b0, 1'b1, 4'b0000, 10'b00_0_0_1_0000_1};
        tbl[16] = '{1'b0, 1'b1, 4'b0000, 10'b00_0_0_1_0000_1};
        tbl[17] = '{1'b0, 1'b1, 4'b0000, 10'b00_0_0_0_0000_0};
        tbl[18] = '{1'b0, 1'b0, 4'b0000, 10'b00_0_0_0_0000_0};

        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].r, tbl[i].t, tbl[i].c);
            check($sformatf("table[%0d]", i), dut_vec, tbl[i].exp);
        end

        // Scenario 3: moving up 1->3, calls for 0 and 2 injected mid-travel
        cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b1000);
        cyc(1'b0, 1'b1, 4'b0000);
        cyc(1'b0, 1'b1, 4'b0000);
        check("scan_at_floor1", dut_vec, 10'b01_1_0_0_1000_1);
        cyc(1'b0, 1'b0, 4'b0101);
        door_floors.delete();
        prev_door = door_open;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b1, 4'b0000);
            if (door_open && !prev_door) door_floors.push_back(int'(current_floor));
            prev_door = door_open;
        end
        check("scan_stop_count", 10'(door_floors.size()), 10'd3);
        if (door_floors.size() == 3) begin
            check("scan_stop0", 10'(door_floors[0]), 10'd2);
            check("scan_stop1", 10'(door_floors[1]), 10'd3);
            check("scan_stop2", 10'(door_floors[2]), 10'd0);
        end
        check("scan_done", dut_vec, 10'b00_0_0_0_0000_0);

        // Scenario 4: re-open at floor 2 after 3 dwell ticks
        cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0100);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 4'b0000);
        check("door_at_2", dut_vec, 10'b10_0_0_1_0000_1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0100);
        check("reopen_no_pending", dut_vec, 10'b10_0_0_1_0000_1);
        n_t = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 4'b0000);
            n_t++;
            if (!door_open) break;
        end
        check("reopen_ticks", 10'(n_t), 10'd4);

        // Scenario 5: reset while moving from floor 1 to 2
        cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b1000);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'b0000);
        check("pre_reset_move", dut_vec, 10'b01_1_0_0_1000_1);
        cyc(1'b1, 1'b1, 4'b0000);
        check("mid_move_reset", dut_vec, 10'b00_0_0_0_0000_0);
        cyc(1'b0, 1'b0, 4'b0010);
        cyc(1'b0, 1'b1, 4'b0000);
        cyc(1'b0, 1'b1, 4'b0000);
        check("post_reset_call", dut_vec, 10'b01_0_0_1_0000_1);

        // Scenario 6: call pending, no ticks for 1000 clocks
        cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b1000);
        for (int i = 0; i < 1000; i++) cyc(1'b0, 1'b0, 4'b0000);
        check("frozen_without_tick", dut_vec, 10'b00_1_0_0_1000_1);

        // Randomized traffic against the reference model
        cyc(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 3000; i++) begin
            logic r, t;
            logic [3:0] c;
            r = ($urandom_range(0, 299) == 0);
            t = 1'($urandom_range(0, 1));
            c = 4'($urandom) & 4'($urandom) & 4'($urandom);
            cyc(r, t, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
